// File: rtl/rc_req_initiator_if.sv
// Active-low request/acknowledge pair between the requester and the responder.
// Valid/ready: rc_reqn low is "valid" and is held until rc_ackn pulses low for
// one cycle ("ready"); the transfer completes on the clock edge that samples it.
interface rc_req_initiator_if;
  logic rc_reqn;
  logic rc_ackn;

  modport master (output rc_reqn, input rc_ackn);
  modport slave  (input rc_reqn, output rc_ackn);
endinterface

// File: rtl/rc_req_initiator.sv
// Requester FSM: turns start pulses into a held-low rc_reqn, releases it on ack
// or timeout, and enforces a release gap. Holds at most one start in reserve.
module rc_req_initiator #(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  rc_req_initiator_if.master     rc,
  output logic                   busy,
  output logic                   done,
  output logic                   tout,
  output logic [CNT_W-1:0]       done_cnt,
  output logic [CNT_W-1:0]       tout_cnt,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  state_t            state;
  logic              pending;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rc.rc_reqn <= 1'b1;
      done       <= 1'b0;
      tout       <= 1'b0;
      done_cnt   <= '0;
      tout_cnt   <= '0;
      pending    <= 1'b0;
      wait_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      tout <= 1'b0;
      case (state)
        IDLE: begin
          // A start captured on the last GAP cycle launches from here.
          if (abort) begin
            pending <= 1'b0;
          end else if (start || pending) begin
            state      <= REQ;
            rc.rc_reqn <= 1'b0;
            wait_cnt   <= '0;
            pending    <= 1'b0;
          end
        end
        REQ: begin
          if (abort) begin
            state      <= GAP;
            rc.rc_reqn <= 1'b1;
            gap_cnt    <= '0;
            pending    <= 1'b0;
          end else begin
            if (start) pending <= 1'b1;
            if (!rc.rc_ackn) begin
              state      <= GAP;
              rc.rc_reqn <= 1'b1;
              gap_cnt    <= '0;
              done       <= 1'b1;
              done_cnt   <= (done_cnt == '1) ? done_cnt : done_cnt + 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
              state      <= GAP;
              rc.rc_reqn <= 1'b1;
              gap_cnt    <= '0;
              tout       <= 1'b1;
              tout_cnt   <= (tout_cnt == '1) ? tout_cnt : tout_cnt + 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (pending && !abort) begin
              state      <= REQ;
              rc.rc_reqn <= 1'b0;
              wait_cnt   <= '0;
              pending    <= start;
            end else begin
              state   <= IDLE;
              pending <= start && !abort;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            if (abort)      pending <= 1'b0;
            else if (start) pending <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          rc.rc_reqn <= 1'b1;
          pending    <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE) || pending;
  assign fsm_state = state;

endmodule
